// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_pkg                                                |
// | Description : Shared defaults and FSM state encoding for the         |
// |               two-port memory arbiter.                               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package mem_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : memory                                                 |
// | Description : Single-port 2**AW x DW storage. Write on WR, registered|
// |               read data on RD.                                       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module memory #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          CLK,
    input  logic          WR,
    input  logic          RD,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D_IN,
    output logic [DW-1:0] Q
);

    logic [DW-1:0] mem_q [2**AW];

    // Storage array write port and registered read port
    always_ff @(posedge CLK) begin
        if (WR) begin
            mem_q[A] <= D_IN;
        end
        if (RD) begin
            Q <= mem_q[A];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arb2                                                |
// | Description : Combinational two-way round-robin pick. On a tie the   |
// |               requester that was not served last wins.               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module rr_arb2
    import mem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win,
    output logic valid
);

    // Winner index: lone requester wins, a tie goes to the one != last
    always_comb begin
        valid = req0 | req1;
        win   = (req0 & req1) ? ~last : req1;
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arbiter                                            |
// | Description : Round-robin arbiter and access sequencer putting two   |
// |               REQ/DONE requesters onto one single-port memory.       |
// |               Every output is registered.                            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] A0,
    input  logic [AW-1:0] A1,
    input  logic [DW-1:0] D0,
    input  logic [DW-1:0] D1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          DONE0,
    output logic          DONE1,
    output logic [DW-1:0] RDATA,
    output logic          M_WR,
    output logic          M_RD,
    output logic [AW-1:0] M_A,
    output logic [DW-1:0] M_D,
    input  logic [DW-1:0] M_Q
);

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic          win_q, win_d;
    logic          we_q, we_d;
    logic          last_q, last_d;
    logic          m_wr_q, m_wr_d;
    logic          m_rd_q, m_rd_d;
    logic [AW-1:0] m_a_q, m_a_d;
    logic [DW-1:0] m_d_q, m_d_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          arb_win;
    logic          arb_valid;

    rr_arb2 u_rr_arb2 (
        .req0  (REQ0),
        .req1  (REQ1),
        .last  (last_q),
        .win   (arb_win),
        .valid (arb_valid)
    );

    // Next-state and registered-output values; memory strobes default low
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        win_d   = win_q;
        we_d    = we_q;
        last_d  = last_q;
        m_wr_d  = 1'b0;
        m_rd_d  = 1'b0;
        m_a_d   = m_a_q;
        m_d_d   = m_d_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    // Latch the winner's request straight into the memory-side registers
                    win_d   = arb_win;
                    we_d    = arb_win ? WE1 : WE0;
                    gnt_d   = arb_win ? 2'b10 : 2'b01;
                    m_a_d   = arb_win ? A1 : A0;
                    if (we_d) begin
                        m_d_d = arb_win ? D1 : D0;
                    end
                    m_wr_d  = we_d;
                    m_rd_d  = ~we_d;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Memory performs the access at the edge closing this cycle
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Read data is on M_Q now; capture it so it lines up with DONE
                if (!we_q) begin
                    rdata_d = M_Q;
                end
                done_d  = win_q ? 2'b10 : 2'b01;
                state_d = S_DONE;
            end
            S_DONE: begin
                gnt_d   = 2'b00;
                last_d  = win_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= 1'b1;
            m_wr_q  <= 1'b0;
            m_rd_q  <= 1'b0;
            m_a_q   <= '0;
            m_d_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            win_q   <= win_d;
            we_q    <= we_d;
            last_q  <= last_d;
            m_wr_q  <= m_wr_d;
            m_rd_q  <= m_rd_d;
            m_a_q   <= m_a_d;
            m_d_q   <= m_d_d;
            rdata_q <= rdata_d;
        end
    end

    assign GNT0  = gnt_q[0];
    assign GNT1  = gnt_q[1];
    assign DONE0 = done_q[0];
    assign DONE1 = done_q[1];
    assign RDATA = rdata_q;
    assign M_WR  = m_wr_q;
    assign M_RD  = m_rd_q;
    assign M_A   = m_a_q;
    assign M_D   = m_d_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                         |
// | Description : Self-checking bench for mem_arbiter + memory, with a   |
// |               transaction-level reference model.                     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ0 = 1'b0, REQ1 = 1'b0;
    logic       WE0 = 1'b0, WE1 = 1'b0;
    logic [3:0] A0 = '0, A1 = '0, D0 = '0, D1 = '0;
    logic       GNT0, GNT1, DONE0, DONE1, M_WR, M_RD;
    logic [3:0] RDATA, M_A, M_D, M_Q;

    int checks = 0;
    int errors = 0;

    // Reference model: requester view, memory contents, fairness pointer
    logic       r_we [2];
    logic [3:0] r_a  [2];
    logic [3:0] r_d  [2];
    bit         pend [2];
    logic [3:0] ref_mem [16];
    logic [3:0] rd_m;
    int         last_m;

    mem_arbiter #(.AW(4), .DW(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .A0(A0), .A1(A1), .D0(D0), .D1(D1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .RDATA(RDATA), .M_WR(M_WR), .M_RD(M_RD), .M_A(M_A), .M_D(M_D),
        .M_Q(M_Q)
    );

    memory #(.AW(4), .DW(4)) u_mem (
        .CLK(CLK), .WR(M_WR), .RD(M_RD), .A(M_A), .D_IN(M_D), .Q(M_Q)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
        chk("gnt_exclusive", {31'd0, GNT0 & GNT1}, 32'd0);
    endtask

    task automatic issue(input int i, input logic we, input logic [3:0] a, input logic [3:0] d);
        r_we[i] = we; r_a[i] = a; r_d[i] = d; pend[i] = 1'b1;
        if (i == 0) begin REQ0 = 1'b1; WE0 = we; A0 = a; D0 = d; end
        else        begin REQ1 = 1'b1; WE1 = we; A1 = a; D1 = d; end
    endtask

    task automatic drop(input int i);
        pend[i] = 1'b0;
        if (i == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
    endtask

    task automatic issue_rand(input int i);
        issue(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    // Wait for one complete transaction by requester `who`; returns in its DONE cycle.
    // exp_gt = ticks until the grant is visible; inject raises a write on port 1 mid-access.
    task automatic serve(input int who, input int exp_gt, input bit inject);
        int t  = 0;
        int gt = -1;
        bit got_d = 1'b0;
        logic [1:0] onehot = (who == 1) ? 2'b10 : 2'b01;
        while (!got_d && t < 16) begin
            tick();
            t++;
            if (inject && t == 1) issue(1, 1'b1, 4'h6, 4'h5);
            if (gt < 0 && (GNT0 || GNT1)) begin
                gt = t;
                chk("grant_lat", t, exp_gt);
                chk("grant_who", {30'd0, GNT1, GNT0}, {30'd0, onehot});
                chk("access_wr", {31'd0, M_WR}, {31'd0, r_we[who]});
                chk("access_rd", {31'd0, M_RD}, {31'd0, ~r_we[who]});
                chk("access_a", {28'd0, M_A}, {28'd0, r_a[who]});
                if (r_we[who]) chk("access_d", {28'd0, M_D}, {28'd0, r_d[who]});
            end
            if (DONE0 || DONE1) begin
                got_d = 1'b1;
                chk("done_lat", t - gt, 2);
                chk("done_who", {30'd0, DONE1, DONE0}, {30'd0, onehot});
                chk("done_gnt", {30'd0, GNT1, GNT0}, {30'd0, onehot});
                chk("done_idle_mem", {30'd0, M_WR, M_RD}, 32'd0);
                chk("done_addr", {28'd0, M_A}, {28'd0, r_a[who]});
                if (r_we[who]) begin
                    ref_mem[r_a[who]] = r_d[who];
                end else begin
                    rd_m = ref_mem[r_a[who]];
                end
                chk("rdata", {28'd0, RDATA}, {28'd0, rd_m});
                last_m = who;
            end
        end
        if (!got_d) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int who, gt, sel, other;
        pend[0] = 1'b0; pend[1] = 1'b0;
        last_m = 1; rd_m = 4'h0;

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", {14'd0, GNT1, GNT0, DONE1, DONE0, M_WR, M_RD, M_A, M_D, RDATA}, 32'd0);
        RST_N = 1'b1;
        tick();

        // Single write from port 0, then write from port 1, then readbacks
        issue(0, 1'b1, 4'b0011, 4'b1001); serve(0, 1, 1'b0); drop(0); tick();
        issue(1, 1'b1, 4'b1101, 4'b1010); serve(1, 1, 1'b0); drop(1); tick();
        issue(0, 1'b0, 4'b0011, 4'h0);    serve(0, 1, 1'b0); drop(0); tick();
        issue(1, 1'b0, 4'b1101, 4'h0);    serve(1, 1, 1'b0); drop(1); tick();

        // Simultaneous requests after reset alternate 0,1,0,1
        RST_N = 1'b0; tick(); RST_N = 1'b1; last_m = 1; rd_m = 4'h0; tick();
        issue(0, 1'b1, 4'h1, 4'h1); issue(1, 1'b1, 4'h2, 4'h2);
        serve(0, 1, 1'b0); issue(0, 1'b0, 4'h1, 4'h0);
        serve(1, 2, 1'b0); issue(1, 1'b0, 4'h2, 4'h0);
        serve(0, 2, 1'b0); drop(0);
        serve(1, 2, 1'b0); drop(1); tick();

        // Port 1 arrives during port 0's access and waits its turn
        issue(0, 1'b0, 4'b0011, 4'h0); serve(0, 1, 1'b1); drop(0);
        serve(1, 2, 1'b0); drop(1); tick();

        // Reset during WAIT of a read: outputs clear at once, no DONE
        issue(0, 1'b0, 4'b1101, 4'h0); tick(); tick();
        #2 RST_N = 1'b0;
        #1 chk("async_reset", {14'd0, GNT1, GNT0, DONE1, DONE0, M_WR, M_RD, M_A, M_D, RDATA}, 32'd0);
        drop(0); tick(); tick();
        RST_N = 1'b1; last_m = 1; rd_m = 4'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_done_after_reset", {30'd0, DONE1, DONE0}, 32'd0);
        end
        issue(0, 1'b0, 4'b0011, 4'h0); serve(0, 1, 1'b0); drop(0); tick();

        // REQ0 held across DONE: single-cycle DONE, new transaction follows
        issue(0, 1'b0, 4'b1101, 4'h0); serve(0, 1, 1'b0);
        tick();
        chk("done_single_pulse", {31'd0, DONE0}, 32'd0);
        serve(0, 1, 1'b0); drop(0); tick();

        // Fill every location so random reads have known contents
        for (int a = 0; a < 16; a++) begin
            issue(a % 2, 1'b1, 4'(a), 4'($urandom_range(0, 15)));
            serve(a % 2, 1, 1'b0); drop(a % 2); tick();
        end

        // Random traffic against the model
        for (int k = 0; k < 40; k++) begin
            if (!pend[0] && !pend[1]) begin
                repeat ($urandom_range(1, 3)) tick();
                sel = int'($urandom_range(1, 3));
                if (sel[0]) issue_rand(0);
                if (sel[1]) issue_rand(1);
                gt = 1;
            end else begin
                gt = 2;
            end
            who = (pend[0] && pend[1]) ? ((last_m == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
            serve(who, gt, 1'b0);
            if ($urandom_range(0, 1) == 1) issue_rand(who); else drop(who);
            other = 1 - who;
            if (!pend[other] && $urandom_range(0, 3) == 0) issue_rand(other);
        end
        drop(0); drop(1);
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer for the single-port 16x4 `memory` block (CLK, WR, RD, A, D_IN, Q).
- Two independent requesters (e.g. a loader and a readback unit) each issue one read or write at a time with a REQ/DONE handshake.
- The arbiter serialises their accesses onto the memory's WR/RD/A/D_IN pins and returns read data.
- Sits between the requesters and one `memory` instance.

Parameters:
- AW, 4, address width (memory depth 2**AW).
- DW, 4, data width.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ0, REQ1  input  1 each  access request; held high until DONEx is seen.
- WE0, WE1  input  1 each  1 = write, 0 = read; stable while REQx is high.
- A0, A1  input  AW each  address; stable while REQx is high.
- D0, D1  input  DW each  write data; stable while REQx is high.
- GNT0, GNT1  output  1 each  high from grant until the end of the DONE state.
- DONE0, DONE1  output  1 each  one-cycle completion pulse.
- RDATA  output  DW  read data for the last completed read; valid while DONEx is high, held afterwards.
- M_WR, M_RD  output  1 each  to memory WR and RD.
- M_A  output  AW  to memory A.
- M_D  output  DW  to memory D_IN.
- M_Q  input  DW  from memory Q.

Behaviour:
- Memory contract: it writes D_IN to A on the rising edge where WR=1. Q shows mem[A] after the rising edge where RD=1.
- Reset (RST_N low, asynchronous) forces the following, whether or not a transaction is in flight:
  - state = IDLE
  - GNT0, GNT1, DONE0, DONE1 = 0
  - M_WR = M_RD = 0
  - M_A = 0, M_D = 0, RDATA = 0
  - LAST = 1, so requester 0 wins the first tie.
- An in-flight transaction is abandoned with no DONE. The requester must re-request after RST_N rises.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM (4 states):
  - IDLE: if a REQ is high at the edge, select the winner W, set GNTW=1, latch WE/A/D of W, go to ACCESS. Otherwise stay.
  - ACCESS (1 cycle): M_A = latched address. For a write, M_WR=1 and M_D = latched data. For a read, M_RD=1. The memory performs the operation at the closing edge. Go to WAIT.
  - WAIT (1 cycle): M_WR = M_RD = 0, M_A held. On a read, RDATA <= M_Q at the closing edge. Go to DONE.
  - DONE (1 cycle): DONEW=1, GNTW still 1. At the closing edge, GNTW=0, DONEW=0, LAST <= W, go to IDLE.
- Latency and throughput:
  - Fixed 4 edges from REQ sampled to DONE deasserted.
  - At most one access per 4 cycles.
  - A write completes identically to a read; RDATA is unchanged on writes.
- Handshake: the requester drops REQ (or presents a new request) at the edge that ends DONE. A REQ still high in the following IDLE cycle is treated as a new request.
- Arbitration:
  - Only one REQ high: grant it.
  - Both high in IDLE: grant the requester != LAST (round robin).
  - A request arriving while busy waits. There is no pre-emption.
- A REQ dropped before DONE (protocol violation) does not abort the access. DONE still pulses.
- Addresses are used as-is (AW bits). No range check is needed; all 2**AW locations are valid.

Decomposition:
- Shared package mem_pkg:
  - AW/DW defaults
  - state encoding: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3
- One sub-module, rr_arb2: combinational 2-way round-robin pick from REQ0, REQ1 and LAST, outputting the winner index and a valid flag.
- The FSM and datapath registers stay in mem_arbiter.
- The bench instantiates mem_arbiter and `memory` together.

Test Plan:
- Reset then REQ0=1, WE0=1, A0=4'b0011, D0=4'b1001 -> in the ACCESS cycle M_WR=1, M_A=0011, M_D=1001; DONE0 pulses in the 4th cycle; GNT1 stays 0.
- REQ1 write A1=4'b1101, D1=4'b1010, then REQ0 read A0=0011 -> RDATA=4'b1001 during DONE0. REQ1 read A1=1101 -> RDATA=4'b1010.
- REQ0 and REQ1 rise together after reset (LAST=1) -> requester 0 served first, then 1. Hold both high for 4 transactions -> grants alternate 0,1,0,1.
- REQ1 asserted during requester 0's ACCESS -> REQ1 waits. Grant to 1 occurs at the first IDLE edge after DONE0, and no cycle has GNT0 and GNT1 both high.
- Reset pulse during WAIT of a read -> all outputs 0 immediately (asynchronously), no DONE pulse. After release, a new read returns correct memory contents.
- REQ0 held high across DONE0 -> second transaction starts at the following IDLE edge. DONE0 is a single-cycle pulse for each transaction.
